// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: mode encoding and DAC code constants shared by the sequencer files
package dac_seq_pkg;
  typedef enum logic [2:0] {SAW_DN, SAW_UP, TRI, SQUARE, HOLD} mode_t;
  localparam logic [7:0] DAC_MAX = 8'hFF;
  localparam logic [7:0] DAC_MIN = 8'h00;
  localparam logic [7:0] SQ_HI = 8'hFF;
  localparam logic [7:0] SQ_LO = 8'h00;
endpackage

// File: rtl/dac_wave_sequencer_debounce.sv
// butt_debounce: syncs active-low i_butt_n, accepts a level after DEB_CYCLES stable samples, pulses o_press on accepted press
module butt_debounce #(
  parameter int DEB_CYCLES = 7,
  parameter int DEB_W = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_butt_n,
  output logic o_press
);
  logic r_s1, r_s2, r_lvl, r_press;
  logic [DEB_W-1:0] r_cnt;
  assign o_press = r_press;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_lvl <= 1'b1;
      r_cnt <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1 <= i_butt_n;
      r_s2 <= r_s1;
      r_press <= 1'b0;
      if (r_s2 != r_lvl) begin
        if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          r_lvl <= r_s2;
          r_cnt <= '0;
          r_press <= ~r_s2;
        end else r_cnt <= r_cnt + 1'b1;
      end else r_cnt <= '0;
    end
  end
endmodule

// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: divider-paced 8-bit waveform generator (i_div/i_load_div rate, i_butt mode button) driving o_dac/o_tick/o_mode
module dac_wave_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DIV_W = 13,
  parameter int DEFAULT_DIV = 20,
  parameter int DEB_CYCLES = 7,
  parameter int DEB_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_butt,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_load_div,
  output logic [7:0]       o_dac,
  output logic [2:0]       o_mode,
  output logic             o_tick
);
  logic w_press, w_tick, r_up, r_tick;
  logic [DIV_W-1:0] r_div, r_cnt;
  mode_t r_mode, w_mode_nx;
  logic [7:0] r_dac, r_phase, w_phase_nx, w_wave, w_start, w_tri;
  butt_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_butt_n(i_butt),
    .o_press(w_press)
  );
  assign o_dac = r_dac;
  assign o_mode = r_mode;
  assign o_tick = r_tick;
  // w_start is the entry value of the mode being advanced into
  always_comb begin
    w_tick = r_cnt == r_div;
    w_phase_nx = r_phase + 8'd1;
    w_tri = r_up ? (r_dac == DAC_MAX ? DAC_MAX - 8'd1 : r_dac + 8'd1)
                 : (r_dac == DAC_MIN ? DAC_MIN + 8'd1 : r_dac - 8'd1);
    w_wave = r_dac;
    w_start = DAC_MAX;
    w_mode_nx = SAW_DN;
    case (r_mode)
      SAW_DN: begin w_wave = r_dac - 8'd1; w_mode_nx = SAW_UP; w_start = DAC_MIN; end
      SAW_UP: begin w_wave = r_dac + 8'd1; w_mode_nx = TRI; w_start = DAC_MIN; end
      TRI:    begin w_wave = w_tri; w_mode_nx = SQUARE; w_start = SQ_LO; end
      SQUARE: begin w_wave = w_phase_nx[7] ? SQ_HI : SQ_LO; w_mode_nx = HOLD; w_start = r_dac; end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= SAW_DN;
      r_dac <= DAC_MAX;
      r_tick <= 1'b0;
      r_div <= DIV_W'(DEFAULT_DIV);
      r_cnt <= '0;
      r_up <= 1'b1;
      r_phase <= '0;
    end else begin
      r_tick <= 1'b0;
      if (r_mode > HOLD) r_mode <= SAW_DN;
      if (w_press) begin
        r_mode <= w_mode_nx;
        r_dac <= w_start;
        r_up <= 1'b1;
        r_phase <= '0;
        r_cnt <= '0;
        if (i_load_div) r_div <= i_div;
      end else if (i_load_div) begin
        r_div <= i_div;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
        r_tick <= 1'b1;
        r_dac <= w_wave;
        r_phase <= w_phase_nx;
        if (r_mode == TRI) r_up <= r_dac == DAC_MAX ? 1'b0 : r_dac == DAC_MIN ? 1'b1 : r_up;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dac_wave_sequencer.sv
// tb_dac_wave_sequencer: random and directed stimulus checked each cycle against a behavioural model
module tb_dac_wave_sequencer;
  localparam int DEB = 7;
  logic clk = 1'b0, rst = 1'b1, butt = 1'b1, load = 1'b0;
  logic [12:0] div = '0;
  wire [7:0] o_dac;
  wire [2:0] o_mode;
  wire o_tick;
  int n_chk = 0, n_err = 0;
  int m_dac, m_mode, m_cnt, m_div, m_pos, m_ph, m_s1, m_s2, m_lvl, m_press, m_tick;
  int hist[$];
  dac_wave_sequencer dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_butt(butt),
    .i_div(div),
    .i_load_div(load),
    .o_dac(o_dac),
    .o_mode(o_mode),
    .o_tick(o_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock edge of the reference: button accepted once the last DEB synced samples all disagree with the held level
  task automatic step();
    int pu;
    bit tk, all;
    if (rst) begin
      m_dac = 255; m_mode = 0; m_cnt = 0; m_div = 20; m_pos = 0; m_ph = 0;
      m_s1 = 1; m_s2 = 1; m_lvl = 1; m_press = 0; m_tick = 0;
      hist.delete();
      return;
    end
    pu = m_press;
    m_press = 0;
    hist.push_back(m_s2);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      all = 1;
      foreach (hist[i]) if (hist[i] == m_lvl) all = 0;
      if (all) begin
        m_lvl = m_s2;
        m_press = (m_s2 == 0) ? 1 : 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = int'(butt);
    tk = m_cnt == m_div;
    m_tick = 0;
    if (pu != 0) begin
      m_mode = (m_mode + 1) % 5;
      m_cnt = 0;
      m_pos = 0;
      m_ph = 0;
      if (load) m_div = int'(div);
      if (m_mode == 0) m_dac = 255;
      else if (m_mode != 4) m_dac = 0;
    end else if (load) begin
      m_div = int'(div);
      m_cnt = 0;
    end else if (tk) begin
      m_cnt = 0;
      m_tick = 1;
      case (m_mode)
        0: m_dac = (m_dac + 255) % 256;
        1: m_dac = (m_dac + 1) % 256;
        2: begin m_pos = (m_pos + 1) % 510; m_dac = m_pos <= 255 ? m_pos : 510 - m_pos; end
        3: begin m_ph = (m_ph + 1) % 256; m_dac = m_ph >= 128 ? 255 : 0; end
        default: ;
      endcase
    end else m_cnt++;
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      step();
      @(negedge clk);
      chk("dac", int'(o_dac), m_dac);
      chk("mode", int'(o_mode), m_mode);
      chk("tick", int'(o_tick), m_tick);
    end
  endtask
  task automatic load_div(int v);
    div = 13'(v);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  task automatic press_btn();
    butt = 1'b0;
    cyc(20);
    butt = 1'b1;
    cyc(20);
  endtask
  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(5500);
    load_div(0);
    cyc(300);
    butt = 1'b0;
    cyc(3);
    butt = 1'b1;
    cyc(20);
    chk("glitch_mode", int'(o_mode), 0);
    butt = 1'b0;
    cyc(40);
    butt = 1'b1;
    cyc(20);
    chk("saw_up_mode", int'(o_mode), 1);
    press_btn();
    cyc(600);
    press_btn();
    cyc(600);
    press_btn();
    cyc(50);
    press_btn();
    chk("wrap_mode", int'(o_mode), 0);
    press_btn();
    press_btn();
    butt = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(30);
    chk("rst_press_mode", int'(o_mode), 1);
    butt = 1'b1;
    cyc(20);
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) load_div(int'($urandom_range(0, 4)));
      else if (r < 7) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end else if (r < 45) begin
        butt = 1'($urandom_range(0, 1));
        cyc(int'($urandom_range(1, 15)));
      end else cyc(int'($urandom_range(1, 20)));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
